// File: rtl/eight_bit_wallace_acc_pkg.sv
// Shared types and sizes for the Wallace-tree product accumulator.
package eight_bit_wallace_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam int PRODUCT_WIDTH     = 16;
    localparam int DEFAULT_ACC_WIDTH = 24;
    localparam int DEFAULT_ACC_COUNT = 8;
    localparam int COUNT_WIDTH       = 8;

endpackage

// File: rtl/eight_bit_wallace_acc_adder.sv
// Combinational ripple-carry adder for the accumulator, built from 1-bit full adders.
module one_bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module eight_bit_wallace_acc_adder
    import eight_bit_wallace_acc_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 carry_out
);
    logic [ACC_WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_bit
        one_bit_full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    // The final carry feeds both the sticky overflow flag and saturation.
    assign carry_out = carry[ACC_WIDTH];
endmodule

// File: rtl/eight_bit_wallace_product_accumulator.sv
// Frames up to ACC_COUNT 16-bit products into an ACC_WIDTH-bit sum with valid/ready on both sides.
// Define ACC_SATURATE_EN to clamp the sum at all-ones on carry-out instead of wrapping.
module eight_bit_wallace_product_accumulator
    import eight_bit_wallace_acc_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
    parameter int ACC_COUNT = DEFAULT_ACC_COUNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PRODUCT_WIDTH-1:0] in_product,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_sum,
    output logic [COUNT_WIDTH-1:0]   out_count,
    output logic                     out_overflow
);
    acc_state_t             state, state_n;
    logic [ACC_WIDTH-1:0]   acc, acc_n, product_ext, add_sum;
    logic                   add_carry;
    logic [COUNT_WIDTH-1:0] count, count_n, count_inc;
    logic                   overflow, overflow_n;
    logic                   in_ready_q, out_valid_q;
    logic                   accept;

    assign product_ext = ACC_WIDTH'(in_product);
    assign accept      = in_valid & in_ready_q;
    assign count_inc   = count + COUNT_WIDTH'(1);

    eight_bit_wallace_acc_adder #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_adder (
        .a        (acc),
        .b        (product_ext),
        .sum      (add_sum),
        .carry_out(add_carry)
    );

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        count_n    = count;
        overflow_n = overflow;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_n      = product_ext;
                    count_n    = COUNT_WIDTH'(1);
                    overflow_n = 1'b0;
                    state_n    = (in_last || ACC_COUNT == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_n = add_sum;
`ifdef ACC_SATURATE_EN
                    if (add_carry) acc_n = '1;
`endif
                    count_n    = count_inc;
                    overflow_n = overflow | add_carry;
                    if (in_last || count_inc == COUNT_WIDTH'(ACC_COUNT)) state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n    = IDLE;
                    acc_n      = '0;
                    count_n    = '0;
                    overflow_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are registered from next state so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            count       <= count_n;
            overflow    <= overflow_n;
            in_ready_q  <= (state_n != DONE);
            out_valid_q <= (state_n == DONE);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = acc;
    assign out_count    = count;
    assign out_overflow = overflow;
endmodule

// File: tb/tb_eight_bit_wallace_product_accumulator.sv
// Directed bench for the product accumulator: a 24-bit/8-product instance and a 17-bit overflow instance.
module tb_eight_bit_wallace_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in_product;
    logic        in_ready, out_valid, out_overflow;
    logic [23:0] out_sum;
    logic [7:0]  out_count;

    logic        s_valid, s_last, s_out_ready;
    logic [15:0] s_product;
    logic        s_in_ready, s_out_valid, s_overflow;
    logic [16:0] s_sum;
    logic [7:0]  s_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    eight_bit_wallace_product_accumulator #(.ACC_WIDTH(24), .ACC_COUNT(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_overflow(out_overflow)
    );

    eight_bit_wallace_product_accumulator #(.ACC_WIDTH(17), .ACC_COUNT(8)) dut17 (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(s_in_ready), .in_product(s_product), .in_last(s_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_sum), .out_count(s_count), .out_overflow(s_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Presents one beat and returns #1 after the edge at which it was accepted.
    task automatic send(input logic [15:0] p, input logic last);
        bit done = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] sum, input logic [31:0] cnt,
                                 input logic ovf);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(out_sum), sum);
        check({tag, "_count"}, 32'(out_count), cnt);
        check({tag, "_ovf"}, 32'(out_overflow), 32'(ovf));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handshake_valid_low", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp17;
        rst = 1'b1;
        in_valid = 0; in_last = 0; in_product = 0; out_ready = 0;
        s_valid = 0; s_last = 0; s_product = 0; s_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Four-product frame closed by in_last
        send(16'd65025, 0);
        send(16'd1, 0);
        send(16'd0, 0);
        send(16'd100, 1);
        expect_result("t1", 32'd65126, 32'd4, 1'b0);
        handshake();

        // Auto-close at ACC_COUNT, then fresh frame
        for (int i = 0; i < 8; i++) send(16'd65025, 0);
        expect_result("t2", 32'd520200, 32'd8, 1'b0);
        handshake();
        send(16'd5, 1);
        expect_result("t2_next", 32'd5, 32'd1, 1'b0);
        handshake();

        // 17-bit accumulator overflow
        s_valid = 1'b1; s_product = 16'd65025;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_last = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
`ifdef ACC_SATURATE_EN
        exp17 = 32'd131071;
`else
        exp17 = 32'd64003;
`endif
        check("t3_valid", 32'(s_out_valid), 32'd1);
        check("t3_sum", 32'(s_sum), exp17);
        check("t3_count", 32'(s_count), 32'd3);
        check("t3_ovf", 32'(s_overflow), 32'd1);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        check("t3_valid_low", 32'(s_out_valid), 32'd0);

        // Back-pressure in DONE with a pending product
        send(16'd7, 1);
        in_valid = 1'b1; in_product = 16'd200; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_in_ready", 32'(in_ready), 32'd0);
            check("t4_out_valid", 32'(out_valid), 32'd1);
            check("t4_sum_stable", 32'(out_sum), 32'd7);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t4_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("t4_held", 32'd200, 32'd1, 1'b0);
        handshake();

        // Single-product frame, bubble, then back-to-back frames
        send(16'd16, 1);
        expect_result("t5", 32'd16, 32'd1, 1'b0);
        handshake();
        @(posedge clk); #1;
        in_valid = 1'b1; in_product = 16'd3; in_last = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_b2b_v1", 32'(out_valid), 32'd1);
        check("t5_b2b_s1", 32'(out_sum), 32'd3);
        in_product = 16'd4;
        @(posedge clk); #1;
        check("t5_b2b_gap", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t5_b2b_v2", 32'(out_valid), 32'd1);
        check("t5_b2b_s2", 32'(out_sum), 32'd4);
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t5_b2b_end", 32'(out_valid), 32'd0);

        // Reset mid-frame
        send(16'd1000, 0);
        send(16'd2000, 0);
        #2 rst = 1'b1;
        #1;
        check("t6_mid_valid", 32'(out_valid), 32'd0);
        check("t6_mid_in_ready", 32'(in_ready), 32'd1);
        check("t6_mid_sum", 32'(out_sum), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        send(16'd9, 1);
        expect_result("t6a", 32'd9, 32'd1, 1'b0);
        handshake();

        // Reset while holding a result
        send(16'd50, 1);
        check("t6_done_pre", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_done_valid", 32'(out_valid), 32'd0);
        check("t6_done_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        send(16'd11, 1);
        expect_result("t6b", 32'd11, 32'd1, 1'b0);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eight_bit_wallace_product_accumulator.md
Name: eight_bit_wallace_product_accumulator

Overview:
Sequential stage directly downstream of the final Wallace-tree reduction layer of the 8-bit approximate multiplier. It registers each 16-bit product and accumulates up to ACC_COUNT products per frame into an ACC_WIDTH-bit sum. It uses valid/ready handshakes on both sides, so the combinational multiplier array can feed a dot-product / MAC datapath.

Parameters:
ACC_WIDTH, 24, accumulator and result width in bits; legal range 16 to 32.
ACC_COUNT, 8, maximum number of products per frame; legal range 1 to 255. A frame closes early on in_last.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_product and in_last are valid
in_ready  output  1  block can accept a product this cycle
in_product  input  16  product from the reduction tree; bit i has weight 2^i (bit 0 = weight 1, bit 15 = weight 32768)
in_last  input  1  this product closes the frame
out_valid  output  1  out_sum, out_count and out_overflow are valid
out_ready  input  1  consumer accepts the result
out_sum  output  ACC_WIDTH  accumulated frame sum
out_count  output  8  number of products in the frame (1 to ACC_COUNT)
out_overflow  output  1  sticky flag: a carry left bit ACC_WIDTH-1 during this frame

Behaviour:
- Clocking: one clock, clk. rst is asynchronous and active-high.
- Reset: state=IDLE, acc=0, count=0, overflow=0, out_valid=0, in_ready=1. out_sum and out_count reset to 0.
- FSM has three states: IDLE, ACCUM, DONE.
- Accept condition: in_valid & in_ready. in_ready = (state != DONE), registered from next state; there is no combinational path from out_ready to in_ready.
- IDLE, on accept:
  - acc <= zero-extended in_product; count <= 1; overflow <= 0.
  - Go to DONE if in_last or ACC_COUNT==1; otherwise go to ACCUM.
- ACCUM, on accept:
  - acc <= acc + zero-extended in_product; count <= count+1; overflow |= carry out of bit ACC_WIDTH-1.
  - Go to DONE if in_last or count+1==ACC_COUNT.
- No accept in IDLE or ACCUM: all state held. Bubbles (in_valid low) are allowed mid-frame.
- DONE:
  - out_valid=1; out_sum, out_count and out_overflow are held stable until the handshake.
  - On out_ready: go to IDLE, out_valid falls next cycle, acc and count clear.
- Latency: the result is visible on out_valid the cycle after the final accept. Minimum frame period is 2 cycles with out_ready held high.
- Frame boundaries:
  - in_last on the first beat gives a single-product frame.
  - ACC_COUNT reached without in_last closes the frame; the next beat starts a new frame.
  - in_last arriving together with the count limit gives one close, not two.
- Simultaneous events: in_valid while in DONE is back-pressured (in_ready=0); the product is not lost, and the upstream source holds it.
- Arithmetic: unsigned. Without the optional feature, the sum wraps modulo 2^ACC_WIDTH.
- Reset mid-frame or in DONE: the partial sum is discarded, out_valid drops immediately (asynchronously), and the block returns to IDLE.

Optional Feature:
ACC_SATURATE_EN
- Defined: any addition that carries out clamps acc to all-ones (2^ACC_WIDTH-1) and holds it there for the rest of the frame. out_overflow is still set.
- Undefined: the sum wraps, and out_overflow marks that the wrap occurred.

Decomposition:
- Package eight_bit_wallace_acc_pkg contains:
  - the state enum (IDLE, ACCUM, DONE);
  - PRODUCT_WIDTH=16;
  - default ACC_WIDTH and ACC_COUNT;
  - COUNT_WIDTH=8.
- One natural sub-module: eight_bit_wallace_acc_adder. It is a combinational ACC_WIDTH-bit ripple adder built from one_bit_full_adder instances, with carry-out exposed for overflow and saturation. FSM, counters and registers stay in the top.

Test Plan:
1. Reset, then frame of 4 products with ACC_COUNT=8: 255*255=65025, 1, 0, 100 with in_last on the 4th -> out_sum=65126, out_count=4, out_overflow=0, out_valid one cycle after the last accept.
2. ACC_COUNT=8 with no in_last: eight products of 65025 -> frame auto-closes, out_sum=520200, out_count=8; the 9th product starts a new frame with out_sum base 0.
3. ACC_WIDTH=17, three products of 65025, in_last on the 3rd -> without the macro out_sum=64003 and out_overflow=1; with ACC_SATURATE_EN out_sum=131071 and out_overflow=1.
4. Back-pressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, result stable all 5 cycles, no product consumed; release -> next frame begins with the held product.
5. Single-product frame: in_product=16 with in_last, then a 1-cycle bubble -> out_sum=16, out_count=1; back-to-back frames with out_ready=1 sustain one result per 2 cycles.
6. Assert rst mid-frame after 2 accepts, and again during DONE -> out_valid=0 asynchronously, in_ready=1; the next frame's sum excludes the discarded partials.
